// File: rtl/kd_half_butterfly_pkg.sv
// ============================================================================
// Module      : kd_pkg
// Description : Shared moduli, lane widths and mode encoding for the
//               Kyber/Dilithium inverse-butterfly datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kd_pkg;

    localparam int K_W = 12;
    localparam int D_W = 24;

    localparam logic [K_W-1:0] KQ = 12'd3329;
    localparam logic [D_W-1:0] DQ = 24'd8380417;

    typedef enum logic {
        MODE_KYBER = 1'b0,
        MODE_DIL   = 1'b1
    } kd_mode_e;

endpackage

`default_nettype wire

// File: rtl/kd_half_butterfly_if.sv
// ============================================================================
// Module      : kd_half_butterfly_if
// Description : Operand/result valid-ready bundle of the half-butterfly unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kd_half_butterfly_if;

    logic                    KD_mode;
    logic                    in_valid;
    logic                    in_ready;
    logic [kd_pkg::D_W-1:0]  a_in;
    logic [kd_pkg::D_W-1:0]  b_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [kd_pkg::D_W-1:0]  sum_out;
    logic [kd_pkg::D_W-1:0]  diff_out;

    modport master (
        output KD_mode, in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, sum_out, diff_out
    );

    modport slave (
        input  KD_mode, in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, sum_out, diff_out
    );

endinterface

`default_nettype wire

// File: rtl/kd_half_butterfly_mod_half.sv
// ============================================================================
// Module      : kd_mod_half
// Description : Combinational modular halving: x/2 mod Q for odd Q, x < Q.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kd_mod_half #(
    parameter int           W = 12,
    parameter logic [W-1:0] Q = '0
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    // Odd values borrow one modulus; the add is one bit wider so it cannot wrap.
    assign y = x[0] ? W'(({1'b0, x} + {1'b0, Q}) >> 1) : (x >> 1);

endmodule

`default_nettype wire

// File: rtl/kd_half_butterfly.sv
// ============================================================================
// Module      : kd_half_butterfly
// Description : Two-stage modular add/sub-and-halve for Kyber (2x12b lanes)
//               or Dilithium (1x24b lane). Halving enabled by KD_HALVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kd_half_butterfly
    import kd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    kd_half_butterfly_if.slave  bus
);

    function automatic logic [K_W-1:0] k_add(input logic [K_W-1:0] a, input logic [K_W-1:0] b);
        logic [K_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s[K_W] || (s[K_W-1:0] >= KQ)) ? (s[K_W-1:0] - KQ) : s[K_W-1:0];
    endfunction

    function automatic logic [K_W-1:0] k_sub(input logic [K_W-1:0] a, input logic [K_W-1:0] b);
        logic [K_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[K_W] ? (d[K_W-1:0] + KQ) : d[K_W-1:0];
    endfunction

    function automatic logic [D_W-1:0] d_add(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        logic [D_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s[D_W] || (s[D_W-1:0] >= DQ)) ? (s[D_W-1:0] - DQ) : s[D_W-1:0];
    endfunction

    function automatic logic [D_W-1:0] d_sub(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        logic [D_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[D_W] ? (d[D_W-1:0] + DQ) : d[D_W-1:0];
    endfunction

    logic             w_en1;
    logic             w_en2;
    logic [D_W-1:0]   w_s1_sum;
    logic [D_W-1:0]   w_s1_diff;
    logic [D_W-1:0]   w_s2_sum;
    logic [D_W-1:0]   w_s2_diff;

    logic             r_v1;
    logic             r_v2;
    logic [D_W-1:0]   r_s1_sum;
    logic [D_W-1:0]   r_s1_diff;
    logic [D_W-1:0]   r_sum;
    logic [D_W-1:0]   r_diff;

    assign w_en2        = ~r_v2 | bus.out_ready;
    assign w_en1        = ~r_v1 | w_en2;
    assign bus.in_ready = w_en1;

    // Kyber lanes are reduced independently; no carry crosses bit 11/12.
    always_comb begin
        w_s1_sum  = '0;
        w_s1_diff = '0;
        if (bus.KD_mode == MODE_DIL) begin
            w_s1_sum  = d_add(bus.a_in, bus.b_in);
            w_s1_diff = d_sub(bus.a_in, bus.b_in);
        end else begin
            w_s1_sum  = {k_add(bus.a_in[D_W-1:K_W], bus.b_in[D_W-1:K_W]),
                         k_add(bus.a_in[K_W-1:0],   bus.b_in[K_W-1:0])};
            w_s1_diff = {k_sub(bus.a_in[D_W-1:K_W], bus.b_in[D_W-1:K_W]),
                         k_sub(bus.a_in[K_W-1:0],   bus.b_in[K_W-1:0])};
        end
    end

`ifdef KD_HALVE_EN
    kd_mode_e         r_mode1;
    logic [K_W-1:0]   w_hs_h, w_hs_l, w_hd_h, w_hd_l;
    logic [D_W-1:0]   w_hs_d, w_hd_d;

    kd_mod_half #(.W(K_W), .Q(KQ)) u_half_sum_h  (.x(r_s1_sum[D_W-1:K_W]),  .y(w_hs_h));
    kd_mod_half #(.W(K_W), .Q(KQ)) u_half_sum_l  (.x(r_s1_sum[K_W-1:0]),    .y(w_hs_l));
    kd_mod_half #(.W(K_W), .Q(KQ)) u_half_diff_h (.x(r_s1_diff[D_W-1:K_W]), .y(w_hd_h));
    kd_mod_half #(.W(K_W), .Q(KQ)) u_half_diff_l (.x(r_s1_diff[K_W-1:0]),   .y(w_hd_l));
    kd_mod_half #(.W(D_W), .Q(DQ)) u_half_sum_d  (.x(r_s1_sum),             .y(w_hs_d));
    kd_mod_half #(.W(D_W), .Q(DQ)) u_half_diff_d (.x(r_s1_diff),            .y(w_hd_d));

    assign w_s2_sum  = (r_mode1 == MODE_DIL) ? w_hs_d : {w_hs_h, w_hs_l};
    assign w_s2_diff = (r_mode1 == MODE_DIL) ? w_hd_d : {w_hd_h, w_hd_l};
`else
    assign w_s2_sum  = r_s1_sum;
    assign w_s2_diff = r_s1_diff;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_s1_sum  <= '0;
            r_s1_diff <= '0;
            r_sum     <= '0;
            r_diff    <= '0;
`ifdef KD_HALVE_EN
            r_mode1   <= MODE_KYBER;
`endif
        end else begin
            if (w_en1) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_sum  <= w_s1_sum;
                    r_s1_diff <= w_s1_diff;
`ifdef KD_HALVE_EN
                    r_mode1   <= kd_mode_e'(bus.KD_mode);
`endif
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_sum  <= w_s2_sum;
                    r_diff <= w_s2_diff;
                end
            end
        end
    end

    assign bus.out_valid = r_v2;
    assign bus.sum_out   = r_sum;
    assign bus.diff_out  = r_diff;

endmodule

`default_nettype wire

// File: tb/tb_kd_half_butterfly.sv
// ============================================================================
// Module      : tb_kd_half_butterfly
// Description : Directed-vector and scoreboard bench for kd_half_butterfly;
//               expectations follow KD_HALVE_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kd_half_butterfly;

`ifdef KD_HALVE_EN
    localparam bit HALVE = 1'b1;
`else
    localparam bit HALVE = 1'b0;
`endif
    localparam int KQ_I = 3329;
    localparam int DQ_I = 8380417;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kd_half_butterfly_if intf ();

    kd_half_butterfly dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    typedef struct {
        logic        mode;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] s;
        logic [23:0] d;
    } vec_t;

    vec_t        vecs [6];
    int          errors = 0;
    int          checks = 0;
    logic [47:0] sb [$];
    bit          have_beat = 1'b0;
    logic        cur_m;
    logic [23:0] cur_a, cur_b;
    bit          stall_prev = 1'b0;
    logic [23:0] prev_s, prev_d;
    int          accepts, outputs;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_fix(input int x, input int q);
        if (HALVE) return (x % 2 == 1) ? (x + q) / 2 : x / 2;
        return x % q;
    endfunction

    function automatic logic [47:0] model(input logic m, input logic [23:0] a, input logic [23:0] b);
        int s, d, sh, sl, dh, dl, ah, al, bh, bl;
        if (m) begin
            s = lane_fix((int'(a) + int'(b)) % DQ_I, DQ_I);
            d = lane_fix((int'(a) - int'(b) + DQ_I) % DQ_I, DQ_I);
            return {24'(s), 24'(d)};
        end
        ah = int'(a[23:12]); al = int'(a[11:0]);
        bh = int'(b[23:12]); bl = int'(b[11:0]);
        sh = lane_fix((ah + bh) % KQ_I, KQ_I);
        sl = lane_fix((al + bl) % KQ_I, KQ_I);
        dh = lane_fix((ah - bh + KQ_I) % KQ_I, KQ_I);
        dl = lane_fix((al - bl + KQ_I) % KQ_I, KQ_I);
        return {12'(sh), 12'(sl), 12'(dh), 12'(dl)};
    endfunction

    task automatic new_beat();
        cur_m = 1'($urandom_range(0, 1));
        if (cur_m) begin
            cur_a = 24'($urandom_range(0, DQ_I - 1));
            cur_b = 24'($urandom_range(0, DQ_I - 1));
        end else begin
            cur_a = {12'($urandom_range(0, KQ_I - 1)), 12'($urandom_range(0, KQ_I - 1))};
            cur_b = {12'($urandom_range(0, KQ_I - 1)), 12'($urandom_range(0, KQ_I - 1))};
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, score both sides.
    task automatic step(input bit drv, input bit ordy);
        logic [47:0] e;
        @(negedge clk);
        if (drv && !have_beat) begin
            new_beat();
            have_beat = 1'b1;
        end
        intf.in_valid  = drv;
        intf.KD_mode   = cur_m;
        intf.a_in      = cur_a;
        intf.b_in      = cur_b;
        intf.out_ready = ordy;
        #1;
        if (stall_prev) begin
            check("stall_valid", 24'(intf.out_valid), 24'd1);
            check("stall_sum", intf.sum_out, prev_s);
            check("stall_diff", intf.diff_out, prev_d);
        end
        stall_prev = intf.out_valid && !ordy;
        prev_s     = intf.sum_out;
        prev_d     = intf.diff_out;
        if (intf.out_valid && ordy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got sum %0d with no beat outstanding", intf.sum_out);
            end else begin
                e = sb.pop_front();
                check("stream_sum", intf.sum_out, e[47:24]);
                check("stream_diff", intf.diff_out, e[23:0]);
                outputs++;
            end
        end
        if (drv && intf.in_ready) begin
            sb.push_back(model(cur_m, cur_a, cur_b));
            have_beat = 1'b0;
            accepts++;
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, {12'd2, 12'd3328}, {12'd4, 12'd1},
                   HALVE ? {12'd3, 12'd0}       : {12'd6, 12'd0},
                   HALVE ? {12'd3328, 12'd3328} : {12'd3327, 12'd3327}};
        vecs[1] = '{1'b1, 24'd1, 24'd0,
                   HALVE ? 24'd4190209 : 24'd1,
                   HALVE ? 24'd4190209 : 24'd1};
        vecs[2] = '{1'b1, 24'd0, 24'd1,
                   HALVE ? 24'd4190209 : 24'd1,
                   HALVE ? 24'd4190208 : 24'd8380416};
        vecs[3] = '{1'b0, {12'd0, 12'd3328}, {12'd0, 12'd1},
                   {12'd0, 12'd0},
                   HALVE ? {12'd0, 12'd3328} : {12'd0, 12'd3327}};
        vecs[4] = '{1'b1, 24'd8380416, 24'd8380416,
                   HALVE ? 24'd8380416 : 24'd8380415,
                   24'd0};
        vecs[5] = '{1'b0, {12'd1, 12'd0}, {12'd0, 12'd1},
                   HALVE ? {12'd1665, 12'd1665} : {12'd1, 12'd1},
                   HALVE ? {12'd1665, 12'd1664} : {12'd1, 12'd3328}};

        rst            = 1'b1;
        intf.in_valid  = 1'b0;
        intf.out_ready = 1'b0;
        intf.KD_mode   = 1'b0;
        intf.a_in      = '0;
        intf.b_in      = '0;
        cur_m = 1'b0; cur_a = '0; cur_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 24'(intf.out_valid), 24'd0);
        check("rst_in_ready", 24'(intf.in_ready), 24'd1);
        check("rst_sum", intf.sum_out, 24'd0);
        check("rst_diff", intf.diff_out, 24'd0);
        rst = 1'b0;

        // Directed vectors with exact two-cycle latency.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            intf.KD_mode   = vecs[i].mode;
            intf.a_in      = vecs[i].a;
            intf.b_in      = vecs[i].b;
            intf.in_valid  = 1'b1;
            intf.out_ready = 1'b1;
            #1;
            check("dir_in_ready", 24'(intf.in_ready), 24'd1);
            @(negedge clk);
            intf.in_valid = 1'b0;
            #1;
            check("dir_lat1_valid", 24'(intf.out_valid), 24'd0);
            @(negedge clk);
            #1;
            check("dir_lat2_valid", 24'(intf.out_valid), 24'd1);
            check("dir_sum", intf.sum_out, vecs[i].s);
            check("dir_diff", intf.diff_out, vecs[i].d);
        end
        step(1'b0, 1'b1);

        // Mixed-mode stream at full rate.
        sb.delete();
        stall_prev = 1'b0;
        accepts = 0;
        outputs = 0;
        for (int c = 0; c < 102; c++) step(accepts < 100, 1'b1);
        check("stream_count", 24'(outputs), 24'd100);
        check("stream_drained", 24'(sb.size()), 24'd0);

        // Backpressure: two beats fill the pipe, then input stalls.
        accepts = 0;
        outputs = 0;
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
        check("bp_accepts", 24'(accepts), 24'd2);
        check("bp_in_ready", 24'(intf.in_ready), 24'd0);
        for (int c = 0; c < 12; c++) step(accepts < 6, 1'b1);
        check("bp_outputs", 24'(outputs), 24'd6);
        check("bp_drained", 24'(sb.size()), 24'd0);

        // Reset with both stages full discards the in-flight beats.
        accepts = 0;
        for (int c = 0; c < 2; c++) step(1'b1, 1'b0);
        @(negedge clk);
        rst           = 1'b1;
        intf.in_valid = 1'b0;
        have_beat     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 24'(intf.out_valid), 24'd0);
        check("mid_rst_sum", intf.sum_out, 24'd0);
        check("mid_rst_diff", intf.diff_out, 24'd0);
        check("mid_rst_in_ready", 24'(intf.in_ready), 24'd1);
        sb.delete();
        stall_prev = 1'b0;
        outputs    = 0;
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
        check("post_rst_outputs", 24'(outputs), 24'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
